utu_param: RTL



---
 rtl/utu_pkg.sv | 60 ++++++
 rtl/utu_debounce.sv | 55 +++++
 rtl/utu_param.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/utu_pkg.sv
// utu_pkg: shared types and helpers for the utu_param user-test unit.
// Display source encoding, button indices, hex font, one-hot decoder.
package utu_pkg;

  typedef enum logic [2:0] {
    DISP_DATA = 3'b001,
    DISP_EDIT = 3'b010,
    DISP_ADDR = 3'b100
  } disp_sel_e;

  localparam int BTN_ENT  = 0;
  localparam int BTN_DEL  = 1;
  localparam int BTN_STEP = 2;
  localparam int BTN_PRE  = 3;
  localparam int BTN_NXT  = 4;
  localparam int BTN_N    = 5;

  function automatic logic [6:0] hex2seg(
    input logic [3:0] h
  );
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  // {valid, idx}: valid only when exactly one bit is set.
  function automatic logic [4:0] onehot16_to_idx(
    input logic [15:0] v
  );
    logic [3:0] idx;
    int cnt;
    idx = '0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        idx = 4'(i);
        cnt++;
      end
    end
    return {cnt == 1, idx};
  endfunction

endpackage

// File: rtl/utu_debounce.sv
// utu_debounce: per-bit 2-FF synchroniser plus stability counter.
// RST_LOAD=1 presets everything to the raw input so reset yields no edge.
module utu_debounce #(
  parameter int W        = 1,
  parameter int DB_CYC   = 1000000,
  parameter bit RST_LOAD = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  localparam int CW = $clog2(DB_CYC + 1);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] w_rst_val;

  assign w_rst_val = RST_LOAD ? i_d : '0;

  // two-stage synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= w_rst_val;
      r_s2 <= w_rst_val;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_bit
    logic          r_q;
    logic [CW-1:0] r_cnt;

    // commit after DB_CYC consecutive differing cycles
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
        r_q   <= w_rst_val[g];
      end else if (r_s2[g] == r_q) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYC - 1)) begin
        r_cnt <= '0;
        r_q   <= r_s2[g];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign o_q[g] = r_q;
  end

endmodule

// File: rtl/utu_param.sv
// utu_param: debounced switch/button editor driving a DUT write port.
// Optional auto-repeat of pre/nxt when UTU_AUTOREPEAT_EN is defined.
module utu_param
  import utu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DIGITS      = 8,
  parameter int DB_CYC      = 1000000,
  parameter int SCAN_DIV    = 12500,
  parameter int ADDR_SHOW   = 100000000,
  parameter int REPEAT_DLY  = 50000000,
  parameter int REPEAT_RATE = 10000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       x,
  input  logic              btn_ent,
  input  logic              btn_del,
  input  logic              btn_step,
  input  logic              btn_pre,
  input  logic              btn_nxt,
  input  logic [DATA_W-1:0] tdin,
  output logic [ADDR_W-1:0] taddr,
  output logic [DATA_W-1:0] tdout,
  output logic              twe,
  output logic              step_p,
  output logic              step_stable,
  output logic [2:0]        flag,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int TW = $clog2(ADDR_SHOW + 1);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WW = 4 * DIGITS;

  if (DATA_W % 4 != 0 || DATA_W < ADDR_W ||
      DATA_W > WW || SCAN_DIV % 4 != 0 ||
      REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad
    $error("utu_param: illegal parameters");
  end

  logic [15:0]      w_sw_q;
  logic [15:0]      r_sw_prev;
  logic [BTN_N-1:0] w_btn_raw;
  logic [BTN_N-1:0] w_btn_q;
  logic [BTN_N-1:0] r_btn_prev;
  logic [BTN_N-1:0] w_btn_p;
  logic [4:0]       w_oh;
  logic             w_sw_ev;
  logic [3:0]       w_digit;

  logic [DATA_W-1:0] r_tmp;
  logic [ADDR_W-1:0] r_taddr;
  logic              r_edit;
  disp_sel_e         r_src;
  logic [TW-1:0]     r_timer;
  logic [SW-1:0]     r_div;
  logic [DW-1:0]     r_dig;

  logic w_rpt_pre;
  logic w_rpt_nxt;
  logic w_pre;
  logic w_nxt;
  logic w_do_sw;
  logic w_do_del;
  logic w_do_ent;
  logic w_do_mv;

  assign w_btn_raw = {btn_nxt, btn_pre, btn_step,
                      btn_del, btn_ent};

  utu_debounce #(
    .W(16), .DB_CYC(DB_CYC), .RST_LOAD(1'b1)
  ) u_sw_db (
    .clk(clk), .rst(rst),
    .i_d(x), .o_q(w_sw_q)
  );

  utu_debounce #(
    .W(BTN_N), .DB_CYC(DB_CYC), .RST_LOAD(1'b0)
  ) u_btn_db (
    .clk(clk), .rst(rst),
    .i_d(w_btn_raw), .o_q(w_btn_q)
  );

  // previous committed values for edge/event detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_prev  <= x;
      r_btn_prev <= '0;
    end else begin
      r_sw_prev  <= w_sw_q;
      r_btn_prev <= w_btn_q;
    end
  end

  assign w_btn_p = w_btn_q & ~r_btn_prev;
  assign w_oh    = onehot16_to_idx(w_sw_q ^ r_sw_prev);
  assign w_sw_ev = w_oh[4];
  assign w_digit = w_oh[3:0];

`ifdef UTU_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ?
                        REPEAT_DLY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);

  logic [RW-1:0] r_rpt_cnt;
  logic          r_rpt_ph;
  logic          w_held;
  logic          w_fire;
  logic [RW-1:0] w_tgt;

  assign w_held = (w_btn_q[BTN_PRE] | w_btn_q[BTN_NXT])
                  & ~r_edit;
  assign w_tgt  = r_rpt_ph ? RW'(REPEAT_RATE) :
                             RW'(REPEAT_DLY);
  assign w_fire = w_held & (r_rpt_cnt == w_tgt);

  // hold-time counter: first delay, then repeat period
  always_ff @(posedge clk) begin
    if (rst || !w_held) begin
      r_rpt_cnt <= '0;
      r_rpt_ph  <= 1'b0;
    end else if (w_fire) begin
      r_rpt_cnt <= RW'(1);
      r_rpt_ph  <= 1'b1;
    end else begin
      r_rpt_cnt <= r_rpt_cnt + RW'(1);
    end
  end

  assign w_rpt_pre = w_fire & w_btn_q[BTN_PRE];
  assign w_rpt_nxt = w_fire & w_btn_q[BTN_NXT]
                     & ~w_btn_q[BTN_PRE];
`else
  assign w_rpt_pre = 1'b0;
  assign w_rpt_nxt = 1'b0;
`endif

  assign w_pre    = w_btn_p[BTN_PRE] | w_rpt_pre;
  assign w_nxt    = w_btn_p[BTN_NXT] | w_rpt_nxt;
  assign w_do_sw  = w_sw_ev;
  assign w_do_del = w_btn_p[BTN_DEL] & ~w_sw_ev;
  assign w_do_ent = w_btn_p[BTN_ENT] & ~w_sw_ev
                    & ~w_btn_p[BTN_DEL];
  assign w_do_mv  = (w_pre | w_nxt) & ~w_sw_ev
                    & ~w_btn_p[BTN_DEL]
                    & ~w_btn_p[BTN_ENT];

  // edit word, edit flag and address update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmp   <= '0;
      r_taddr <= '0;
      r_edit  <= 1'b0;
    end else begin
      unique case (1'b1)
        w_do_sw: begin
          r_tmp  <= (r_tmp << 4) | DATA_W'(w_digit);
          r_edit <= 1'b1;
        end
        w_do_del: r_tmp <= r_tmp >> 4;
        w_do_ent: begin
          r_tmp   <= '0;
          r_taddr <= r_taddr + ADDR_W'(1);
          r_edit  <= 1'b0;
        end
        w_do_mv: begin
          if (r_edit) begin
            r_taddr <= r_tmp[ADDR_W-1:0];
            r_tmp   <= '0;
            r_edit  <= 1'b0;
          end else if (w_pre) begin
            r_taddr <= r_taddr - ADDR_W'(1);
          end else begin
            r_taddr <= r_taddr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // display source and address-show timer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src   <= DISP_DATA;
      r_timer <= '0;
    end else begin
      unique case (1'b1)
        w_do_sw, w_do_del: begin
          r_src   <= DISP_EDIT;
          r_timer <= '0;
        end
        w_do_ent: begin
          r_src   <= DISP_DATA;
          r_timer <= '0;
        end
        w_do_mv: begin
          r_src   <= DISP_ADDR;
          r_timer <= TW'(ADDR_SHOW);
        end
        default: begin
          if (r_src == DISP_ADDR) begin
            if (r_timer <= TW'(1)) begin
              r_src   <= DISP_DATA;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
        end
      endcase
    end
  end

  // digit slot divider and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_dig <= '0;
    end else if (r_div == SW'(SCAN_DIV - 1)) begin
      r_div <= '0;
      if (r_dig == DW'(DIGITS - 1)) r_dig <= '0;
      else r_dig <= r_dig + DW'(1);
    end else begin
      r_div <= r_div + SW'(1);
    end
  end

  logic [WW-1:0] w_word;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic          w_off;

  // digit mux, blanking and font lookup
  always_comb begin
    unique case (r_src)
      DISP_EDIT: w_word = WW'(r_tmp);
      DISP_ADDR: w_word = WW'(r_taddr);
      default:   w_word = WW'(tdin);
    endcase
    w_nib   = w_word[{r_dig, 2'b00} +: 4];
    w_blank = r_div < SW'(SCAN_DIV / 4);
    if (r_src == DISP_ADDR) w_off = int'(r_dig) >= ADDR_W / 4;
    else w_off = int'(r_dig) >= DATA_W / 4;
    an  = '1;
    seg = 7'h7F;
    if (!w_blank) begin
      an = ~(DIGITS'(1) << r_dig);
      if (!w_off) seg = hex2seg(w_nib);
    end
  end

  assign taddr       = r_taddr;
  assign tdout       = r_tmp;
  assign twe         = w_do_ent;
  assign step_p      = w_btn_p[BTN_STEP];
  assign step_stable = w_btn_q[BTN_STEP];
  assign flag        = r_src;

endmodule
